round_robin_burst_arbiter: RTL
==============================

// Module: round_robin_burst_arbiter
// PURPOSE
//   Shares one downstream resource among N_REQ requesters, in round-robin order.
//   The grant is registered and held for a multi-cycle burst. It is released when
//   the owner drops its request or has used MAX_BURST beats.
//   Sits between the requesters and the shared resource's select mux.
//   It sequences ownership so that no requester can starve the others.
// PARAMETERS
//   N_REQ      4   number of requesters, >=2
//   MAX_BURST  4   max beats per grant tenure, >=1
// PORTS
//   clk          in   1                     clock, rising edge
//   rst          in   1                     synchronous reset, active-high
//   requests     in   N_REQ                 request per requester, level
//   grants       out  N_REQ                 registered grant, one-hot or zero
//   grant_id     out  $clog2(N_REQ)         binary index of owner; 0 when idle
//   grant_valid  out  1                     |grants
// BEHAVIOUR
//   - Reset: state=IDLE, grants=0, grant_id=0, grant_valid=0, ptr=0, beat_cnt=0.
//     A reset mid-burst clears the grant on the next edge; the burst is dropped.
//   - Beat: a cycle in which grants[o] && requests[o] for owner o.
//   - pick(start, mask): the first set bit of (requests & mask), searched circularly
//     from index start upward.
//   - IDLE: if |requests, then next edge: grants=onehot(w), w=pick(ptr, all),
//     beat_cnt=0, ptr=w+1 mod N_REQ, state=BUSY. Otherwise grants stay 0.
//     Latency is 1 cycle from request to grant.
//   - BUSY with owner o, evaluated each cycle:
//     a) requests[o]=0: not a beat.
//        - w=pick(o+1, ~onehot(o)) exists: next edge grants=onehot(w), ptr=w+1.
//        - No such w: next edge IDLE, grants=0.
//     b) Beat with beat_cnt<MAX_BURST-1: beat_cnt++ and hold the grant.
//     c) Beat with beat_cnt==MAX_BURST-1 (burst exhausted):
//        - w=pick(o+1, all) exists: next edge grants=onehot(w), beat_cnt=0, ptr=w+1.
//          Because the search starts at o+1, o ranks last.
//          If o is the only requester, o is re-granted with a fresh count.
//        - No such w: next edge IDLE, grants=0.
//   - Handover is back-to-back, with no idle bubble between owners.
//   - ptr and all index arithmetic wrap modulo N_REQ. Widths use $clog2(N_REQ),
//     and beat_cnt is $clog2(MAX_BURST+1) bits.
//   - A new request arriving mid-burst never pre-empts the owner.
//   - grants never has more than one bit set. grant_id and grant_valid are
//     derived from the grants register, in the same cycle as grants.
// STRUCTURE
//   - arbiter_pkg: state enum {IDLE, BUSY}, and function
//     rr_pick(req, start, mask) returning {found, index}.
//   - One combinational sub-module, rr_priority_picker (N_REQ param), implements
//     the circular first-set search. It is instanced once; the FSM selects its
//     start and mask inputs.
//   - Top level: FSM, ptr, beat_cnt, grants register, output decode.
// TESTING (N_REQ=4, MAX_BURST=4)
//   - Reset: assert rst with requests=4'b1111. All outputs are 0 each cycle.
//     On release, grants=0001 one cycle later.
//   - Single requester: requests=0100 held for 10 cycles.
//     grants=0100 from cycle 1, with a re-grant every 4 beats and no gap.
//     After requests=0 for one cycle, grants=0 on the next cycle.
//   - Burst limit rotation: requests=1111 held.
//     Grant sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, 0001...
//   - Early release: owner 0 drops its request after 2 beats, with requests=1010.
//     Next grant is 0010. Then, with 1000 still requesting, 1000 follows after its burst.
//   - Fairness on a skipped index: ptr=2, requests=1001. Grant 1000 first.
//     After the burst, grant 0001 and never 1000 twice in a row.
//   - Mid-burst reset: rst pulsed on beat 2 of owner 1. grants=0 next cycle.
//     Arbitration restarts from ptr=0.

Source files
------------

// File: rtl/round_robin_burst_arbiter_pkg.sv
// Shared types and the circular first-set search used by the burst arbiter.
package arbiter_pkg;

    typedef enum logic {IDLE, BUSY} state_t;

    // Widest requester vector the search helper handles.
    localparam int MAX_REQ = 32;

    typedef struct packed {
        logic       found;
        logic [4:0] index;
    } pick_t;

    // Returns the first set bit of (req & mask), searched from 'start' upward and wrapping at n.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [5:0]         start,
                                      input logic [MAX_REQ-1:0] mask,
                                      input logic [5:0]         n);
        pick_t      r;
        logic [5:0] j;
        r = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (6'(i) < n && !r.found) begin
                j = start + 6'(i);
                if (j >= n) j = j - n;
                if (req[j[4:0]] && mask[j[4:0]]) begin
                    r.found = 1'b1;
                    r.index = j[4:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational circular priority search over the request vector.
module rr_priority_picker
    import arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] requests,
    input  logic [IW-1:0]    start,
    input  logic [N_REQ-1:0] mask,
    output logic             found,
    output logic [IW-1:0]    index
);

    pick_t p;
    logic  unused_hi;

    assign p         = rr_pick(MAX_REQ'(requests), 6'(start), MAX_REQ'(mask), 6'(N_REQ));
    assign found     = p.found;
    assign index     = p.index[IW-1:0];
    assign unused_hi = ^p.index;

endmodule

// File: rtl/round_robin_burst_arbiter.sv
// Round-robin arbiter that holds a registered grant for up to MAX_BURST beats.
module round_robin_burst_arbiter
    import arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         requests,
    output logic [N_REQ-1:0]         grants,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     grant_valid
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    state_t           state;
    logic [IW-1:0]    ptr;
    logic [CW-1:0]    beat_cnt;
    logic [IW-1:0]    owner;
    logic [IW-1:0]    start;
    logic [N_REQ-1:0] mask;
    logic             found;
    logic [IW-1:0]    win;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        return (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        owner = '0;
        for (int i = 0; i < N_REQ; i++)
            if (grants[i]) owner = IW'(i);
    end

    assign grant_id    = owner;
    assign grant_valid = |grants;

    // Idle searches from ptr; a busy owner searches past itself, excluding itself only when it let go.
    always_comb begin
        start = ptr;
        mask  = '1;
        if (state == BUSY) begin
            start = next_idx(owner);
            if (!requests[owner]) mask = ~(N_REQ'(1) << owner);
        end
    end

    rr_priority_picker #(.N_REQ(N_REQ), .IW(IW)) u_picker (
        .requests (requests),
        .start    (start),
        .mask     (mask),
        .found    (found),
        .index    (win)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grants   <= '0;
            ptr      <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grants   <= N_REQ'(1) << win;
                        ptr      <= next_idx(win);
                        beat_cnt <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (requests[owner] && beat_cnt < CW'(MAX_BURST - 1)) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end else if (found) begin
                        // Released or exhausted: hand over without a bubble.
                        grants   <= N_REQ'(1) << win;
                        ptr      <= next_idx(win);
                        beat_cnt <= '0;
                    end else begin
                        grants   <= '0;
                        beat_cnt <= '0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    grants <= '0;
                end
            endcase
        end
    end

endmodule
